// File: rtl/game_frame_sequencer.sv
// Per-frame game controller: sequences physics, scroll and collision sweep once per vblank and owns IDLE/RUN/LOSE.
// All outputs registered; reqs are held until done or TIMEOUT_CYC cycles expire; vblank edges seen while busy are dropped.
module game_frame_sequencer #(
  parameter int unsigned NUM_PIPES   = 4,
  parameter int unsigned FRAME_DIV   = 1,
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned SCORE_MAX   = 99
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       vblank,
  input  logic       start,
  input  logic       ack,
  output logic       phys_req,
  input  logic       phys_done,
  output logic       scroll_req,
  input  logic       scroll_done,
  input  logic       scroll_passed,
  output logic [1:0] pipe_idx,
  input  logic       hit,
  output logic [7:0] score,
  output logic       q_idle,
  output logic       q_run,
  output logic       q_lose,
  output logic       busy,
  output logic       timeout_err,
  output logic       overrun
);

  localparam int unsigned WCW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT_CYC - 1);
  localparam logic [WCW-1:0] WAIT_ONE  = WCW'(1);
  localparam logic [3:0]     DIV_LAST  = 4'(FRAME_DIV - 1);
  localparam logic [1:0]     IDX_LAST  = 2'(NUM_PIPES - 1);
  localparam logic [7:0]     SCORE_SAT = 8'(SCORE_MAX);

  // One-hot so the q_* outputs come straight off the state flops.
  typedef enum logic [2:0] {
    G_IDLE = 3'b001,
    G_RUN  = 3'b010,
    G_LOSE = 3'b100
  } game_e;

  typedef enum logic [1:0] {
    F_WAIT   = 2'd0,
    F_PHYS   = 2'd1,
    F_SCROLL = 2'd2,
    F_CHECK  = 2'd3
  } frame_e;

  game_e          game_q, game_d;
  frame_e         frame_q, frame_d;
  logic [3:0]     div_q, div_d;
  logic [WCW-1:0] wait_q, wait_d;
  logic           sub_q, sub_d;
  logic [1:0]     pipe_idx_q, pipe_idx_d;
  logic [7:0]     score_q, score_d;
  logic           phys_req_q, phys_req_d;
  logic           scroll_req_q, scroll_req_d;
  logic           busy_q, busy_d;
  logic           timeout_err_q, timeout_err_d;
  logic           overrun_q, overrun_d;
  logic           vb_s1_q, vb_s1_d;
  logic           vb_s2_q, vb_s2_d;
  logic           vb_s3_q, vb_s3_d;
  logic           vb_edge;

  assign vb_edge = vb_s2_q & ~vb_s3_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      game_q        <= G_IDLE;
      frame_q       <= F_WAIT;
      div_q         <= '0;
      wait_q        <= '0;
      sub_q         <= 1'b0;
      pipe_idx_q    <= '0;
      score_q       <= '0;
      phys_req_q    <= 1'b0;
      scroll_req_q  <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      overrun_q     <= 1'b0;
      vb_s1_q       <= 1'b0;
      vb_s2_q       <= 1'b0;
      vb_s3_q       <= 1'b0;
    end else begin
      game_q        <= game_d;
      frame_q       <= frame_d;
      div_q         <= div_d;
      wait_q        <= wait_d;
      sub_q         <= sub_d;
      pipe_idx_q    <= pipe_idx_d;
      score_q       <= score_d;
      phys_req_q    <= phys_req_d;
      scroll_req_q  <= scroll_req_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
      overrun_q     <= overrun_d;
      vb_s1_q       <= vb_s1_d;
      vb_s2_q       <= vb_s2_d;
      vb_s3_q       <= vb_s3_d;
    end
  end

  always_comb begin
    game_d        = game_q;
    frame_d       = frame_q;
    div_d         = div_q;
    wait_d        = wait_q;
    sub_d         = sub_q;
    pipe_idx_d    = pipe_idx_q;
    score_d       = score_q;
    phys_req_d    = phys_req_q;
    scroll_req_d  = scroll_req_q;
    busy_d        = busy_q;
    timeout_err_d = timeout_err_q;
    overrun_d     = overrun_q;
    vb_s1_d       = vblank;
    vb_s2_d       = vb_s1_q;
    vb_s3_d       = vb_s2_q;

    // An edge during a running sequence is only flagged; it never reaches the divider.
    if (vb_edge && busy_q) begin
      overrun_d = 1'b1;
    end

    case (game_q)
      G_IDLE: begin
        if (start) begin
          game_d  = G_RUN;
          frame_d = F_WAIT;
          score_d = '0;
          div_d   = '0;
        end
      end

      G_LOSE: begin
        if (ack) begin
          game_d = G_IDLE;
        end
      end

      G_RUN: begin
        case (frame_q)
          F_WAIT: begin
            if (vb_edge && !busy_q) begin
              if (div_q == DIV_LAST) begin
                div_d      = '0;
                busy_d     = 1'b1;
                phys_req_d = 1'b1;
                wait_d     = '0;
                frame_d    = F_PHYS;
              end else begin
                div_d = div_q + 4'd1;
              end
            end
          end

          F_PHYS: begin
            if (phys_done) begin
              phys_req_d   = 1'b0;
              scroll_req_d = 1'b1;
              wait_d       = '0;
              frame_d      = F_SCROLL;
            end else if (wait_q == WAIT_LAST) begin
              phys_req_d    = 1'b0;
              timeout_err_d = 1'b1;
              busy_d        = 1'b0;
              game_d        = G_LOSE;
              frame_d       = F_WAIT;
            end else begin
              wait_d = wait_q + WAIT_ONE;
            end
          end

          F_SCROLL: begin
            if (scroll_done) begin
              scroll_req_d = 1'b0;
              if (scroll_passed && (score_q < SCORE_SAT)) begin
                score_d = score_q + 8'd1;
              end
              pipe_idx_d = '0;
              sub_d      = 1'b0;
              frame_d    = F_CHECK;
            end else if (wait_q == WAIT_LAST) begin
              scroll_req_d  = 1'b0;
              timeout_err_d = 1'b1;
              busy_d        = 1'b0;
              game_d        = G_LOSE;
              frame_d       = F_WAIT;
            end else begin
              wait_d = wait_q + WAIT_ONE;
            end
          end

          F_CHECK: begin
            // First cycle of each index drives it; the second samples the registered hit.
            if (!sub_q) begin
              sub_d = 1'b1;
            end else begin
              sub_d = 1'b0;
              if (hit) begin
                game_d     = G_LOSE;
                frame_d    = F_WAIT;
                busy_d     = 1'b0;
                pipe_idx_d = '0;
              end else if (pipe_idx_q == IDX_LAST) begin
                frame_d    = F_WAIT;
                busy_d     = 1'b0;
                pipe_idx_d = '0;
              end else begin
                pipe_idx_d = pipe_idx_q + 2'd1;
              end
            end
          end

          default: begin
            frame_d = F_WAIT;
          end
        endcase
      end

      default: begin
        game_d = G_IDLE;
      end
    endcase
  end

  assign phys_req    = phys_req_q;
  assign scroll_req  = scroll_req_q;
  assign pipe_idx    = pipe_idx_q;
  assign score       = score_q;
  assign q_idle      = game_q[0];
  assign q_run       = game_q[1];
  assign q_lose      = game_q[2];
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;
  assign overrun     = overrun_q;

endmodule
